psk_phase_dispatcher: RTL and testbench
=======================================

Name: psk_phase_dispatcher

Overview:
Parametrised successor to the fixed 6-phase dispatcher in the PSK receive path. It runs a rotating spreading code, correlates the incoming 1-bit `sig` against every code phase over a fixed window, and scans the window scores. It publishes a threshold mask, the best phase and its score through a valid/ready handshake, and tracks phase lock across windows.

Parameters:
- CODE_LEN, 6, code length = number of phases/correlators (>=2).
- CODE_INIT, 6'b000111, initial code register (CODE_LEN bits).
- WINDOW, 64, enabled samples per correlation window; must be >= CODE_LEN+2.
- THRESH, 56, minimum score for a mask bit and for lock qualification (<= WINDOW).
- LOCK_CNT, 3, consecutive qualifying windows on the same phase to assert `locked`.
- SCORE_W (localparam), $clog2(WINDOW+1), score width.
- PH_W (localparam), $clog2(CODE_LEN), phase index width.

Ports:
- clk, in, 1, system clock.
- rst_in, in, 1, synchronous active-high reset.
- sig, in, 1, received hard-decision sample.
- en, in, 1, sample enable; sample accepted on edges where en=1.
- match_mask, out, CODE_LEN, bit j=1 when phase j score >= THRESH.
- best_phase, out, PH_W, index of highest-score phase.
- best_score, out, SCORE_W, score of best_phase.
- out_valid, out, 1, result held valid.
- out_ready, in, 1, consumer accepts result.
- overrun, out, 1, one-cycle pulse when a result is dropped.
- locked, out, 1, phase lock indicator.

Behaviour:
- Reset:
  - Synchronous, active-high. All outputs reset to 0.
  - Code register = CODE_INIT; sample counter, scores, lock run and prev_best = 0; FSM = IDLE.
  - Reset mid-window or mid-scan discards all partial work.
- Code generator: on an accepted sample, code <= {code[CODE_LEN-2:0], code[CODE_LEN-1]}. Phase j uses tap code[j]. Frozen when en=0.
- Correlation:
  - On each accepted sample, score[j] += (sig == code[j]). Scores saturate by construction at WINDOW.
  - Window end is the accepted sample with count == WINDOW-1; that sample is included in the window.
  - At that edge, final scores are loaded into a snapshot bank, live scores and count clear to 0, and the FSM moves IDLE->SCAN.
  - The next accepted sample belongs to the new window.
- FSM:
  - IDLE: waits for window end.
  - SCAN: CODE_LEN cycles, one phase per cycle in index order, independent of en.
    - Sets mask bit j from the snapshot.
    - Updates best only on strictly greater score, so ties resolve to the lowest index.
  - PUBLISH: one cycle, then IDLE.
  - Latency: out_valid rises CODE_LEN+1 cycles after the window-end edge.
- Handshake:
  - A transfer occurs when out_valid & out_ready.
  - Output data is stable while out_valid=1 and no transfer occurs.
  - A transfer with no publish clears out_valid.
  - In PUBLISH:
    - If out_valid=0 or out_ready=1, load the new result and set out_valid=1. Publish and consume in the same cycle are legal.
    - Otherwise keep the old result, drop the new one, and pulse overrun for 1 cycle.
- Lock (updated every PUBLISH, dropped or not):
  - best_score >= THRESH and best == prev_best: run increments, saturating at LOCK_CNT.
  - best_score >= THRESH and best != prev_best: run = 1.
  - best_score < THRESH: run = 0.
  - prev_best <= best. locked is registered as (run >= LOCK_CNT) and takes effect the cycle after PUBLISH.

Decomposition:
- Package psk_pkg:
  - FSM state enum (IDLE, SCAN, PUBLISH).
  - Default CODE_LEN/CODE_INIT constants.
  - Clog2-based width helper functions.
- Sub-module phase_correlator:
  - Instantiated CODE_LEN times via generate.
  - Ports: clk, rst_in, en, sig, code_bit, clr, score.
- Top level holds the code generator, window counter, snapshot bank, FSM, output register and lock tracking.

Test Plan:
Common setup: CODE_LEN=6, CODE_INIT=6'b000111, WINDOW=12, THRESH=11, LOCK_CNT=3.
1. en=1, sig driven equal to model tap code[2] for 12 samples -> after 7 cycles: best_phase=2, best_score=12, match_mask=6'b000100. Snapshot scores: 4,8,12,8,4,0.
2. en=1, sig=0 for 12 samples -> all scores 6; best_phase=0 (tie to lowest index), best_score=6, match_mask=0.
3. out_ready=0 across two scenario-1 windows -> first result held unchanged, overrun pulses exactly 1 cycle at the second PUBLISH. out_ready=1 then yields one transfer and clears out_valid.
4. Three consecutive scenario-1 windows with out_ready=1 -> locked rises 1 cycle after the third PUBLISH. One following sig=0 window -> locked falls after that PUBLISH.
5. en alternating 1/0 over 24 cycles with tap-2 sig on enabled cycles -> same result as scenario 1. rst_in asserted at sample 5 of a window -> no output for that window, the next output reflects a full fresh 12-sample window, and the code register restarts from CODE_INIT.

Source files
------------

// File: rtl/psk_pkg.sv
// psk_pkg: shared constants, FSM encodings and width helpers for the PSK phase dispatcher
package psk_pkg;
    localparam int CODE_LEN_DEF = 6;
    localparam logic [5:0] CODE_INIT_DEF = 6'b000111;
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t SCAN = 2'd1;
    localparam state_t PUBLISH = 2'd2;
    function automatic int score_width(input int window);
        return $clog2(window + 1);
    endfunction
    function automatic int phase_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/psk_phase_dispatcher_correlator.sv
// phase_correlator: counts sample/code-tap agreements over one window
module phase_correlator #(
    parameter int SCORE_W = 7
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic               en,
    input  logic               sig,
    input  logic               code_bit,
    input  logic               clr,
    output logic [SCORE_W-1:0] score
);
    always_ff @(posedge clk) begin
        if (rst_in) score <= '0;
        else if (en) score <= clr ? '0 : score + SCORE_W'(sig == code_bit);
    end
endmodule

// File: rtl/psk_phase_dispatcher.sv
// psk_phase_dispatcher: correlates sig against every code phase per window, scans, publishes and tracks lock
module psk_phase_dispatcher
    import psk_pkg::*;
#(
    parameter int CODE_LEN = CODE_LEN_DEF,
    parameter logic [CODE_LEN-1:0] CODE_INIT = CODE_INIT_DEF,
    parameter int WINDOW = 64,
    parameter int THRESH = 56,
    parameter int LOCK_CNT = 3,
    localparam int SCORE_W = score_width(WINDOW),
    localparam int PH_W = phase_width(CODE_LEN)
) (
    input  logic                clk,
    input  logic                rst_in,
    input  logic                sig,
    input  logic                en,
    output logic [CODE_LEN-1:0] match_mask,
    output logic [PH_W-1:0]     best_phase,
    output logic [SCORE_W-1:0]  best_score,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun,
    output logic                locked
);
    localparam int CNT_W = $clog2(WINDOW);
    localparam int RUN_W = $clog2(LOCK_CNT + 1);
    logic [CODE_LEN-1:0] code, mask_acc;
    logic [CNT_W-1:0]    cnt;
    logic [SCORE_W-1:0]  score [CODE_LEN];
    logic [SCORE_W-1:0]  snap [CODE_LEN];
    logic [SCORE_W-1:0]  best_val;
    logic [PH_W-1:0]     idx, best_idx, prev_best;
    logic [RUN_W-1:0]    run, run_next;
    logic                win_end;
    state_t              state;
    assign win_end = en && cnt == CNT_W'(WINDOW - 1);
    for (genvar j = 0; j < CODE_LEN; j++) begin : g_corr
        phase_correlator #(.SCORE_W(SCORE_W)) u_corr (
            .clk(clk), .rst_in(rst_in), .en(en), .sig(sig),
            .code_bit(code[j]), .clr(win_end), .score(score[j])
        );
        // The window's last sample is folded in here since the live score clears on the same edge
        always_ff @(posedge clk) begin
            if (rst_in) snap[j] <= '0;
            else if (win_end) snap[j] <= score[j] + SCORE_W'(sig == code[j]);
        end
    end
    always_comb run_next = best_val < SCORE_W'(THRESH) ? '0 :
                           best_idx != prev_best ? RUN_W'(1) :
                           run == RUN_W'(LOCK_CNT) ? run : run + 1'b1;
    always_ff @(posedge clk) begin
        if (rst_in) begin
            code <= CODE_INIT;
            cnt <= '0;
            state <= IDLE;
            idx <= '0;
            best_idx <= '0;
            best_val <= '0;
            mask_acc <= '0;
            prev_best <= '0;
            run <= '0;
            match_mask <= '0;
            best_phase <= '0;
            best_score <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
            locked <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (en) begin
                code <= {code[CODE_LEN-2:0], code[CODE_LEN-1]};
                cnt <= win_end ? '0 : cnt + 1'b1;
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
            case (state)
                IDLE: if (win_end) begin
                    state <= SCAN;
                    idx <= '0;
                    best_idx <= '0;
                    best_val <= '0;
                    mask_acc <= '0;
                end
                SCAN: begin
                    mask_acc[idx] <= snap[idx] >= SCORE_W'(THRESH);
                    // Strict compare keeps the lowest index on ties
                    if (snap[idx] > best_val) begin
                        best_val <= snap[idx];
                        best_idx <= idx;
                    end
                    idx <= idx + 1'b1;
                    if (idx == PH_W'(CODE_LEN - 1)) state <= PUBLISH;
                end
                PUBLISH: begin
                    state <= IDLE;
                    if (!out_valid || out_ready) begin
                        match_mask <= mask_acc;
                        best_phase <= best_idx;
                        best_score <= best_val;
                        out_valid <= 1'b1;
                    end else overrun <= 1'b1;
                    run <= run_next;
                    prev_best <= best_idx;
                    locked <= run_next >= RUN_W'(LOCK_CNT);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psk_phase_dispatcher.sv
// tb_psk_phase_dispatcher: directed self-checking bench for psk_phase_dispatcher
module tb_psk_phase_dispatcher;
    logic       clk = 1'b0;
    logic       rst_in, sig, en, out_ready;
    logic [5:0] match_mask;
    logic [2:0] best_phase;
    logic [3:0] best_score;
    logic       out_valid, overrun, locked;
    int         n_cmp = 0, n_err = 0, ov_cnt = 0, ov0;
    logic [5:0] code_m;
    int         snap_exp [6] = '{4, 8, 12, 8, 4, 0};

    psk_phase_dispatcher #(
        .CODE_LEN(6), .CODE_INIT(6'b000111), .WINDOW(12), .THRESH(11), .LOCK_CNT(3)
    ) dut (
        .clk(clk), .rst_in(rst_in), .sig(sig), .en(en),
        .match_mask(match_mask), .best_phase(best_phase), .best_score(best_score),
        .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (overrun === 1'b1) ov_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        rst_in = 1'b1;
        en = 1'b0;
        sig = 1'b0;
        tick;
        tick;
        rst_in = 1'b0;
        code_m = 6'b000111;
    endtask

    // tap=1 drives the model's code[2] tap, tap=0 drives constant 0
    task automatic feed(input logic tap, input int n);
        for (int i = 0; i < n; i++) begin
            en = 1'b1;
            sig = tap ? code_m[2] : 1'b0;
            tick;
            code_m = {code_m[4:0], code_m[5]};
            en = 1'b0;
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (out_valid !== 1'b1 && k < 20) begin
            tick;
            k++;
        end
        chk({tag, "_timeout"}, 32'(k < 20), 32'd1);
    endtask

    task automatic chk_res(input string tag, input int ph, input int sc, input int mk);
        chk({tag, "_phase"}, 32'(best_phase), 32'(ph));
        chk({tag, "_score"}, 32'(best_score), 32'(sc));
        chk({tag, "_mask"}, 32'(match_mask), 32'(mk));
    endtask

    initial begin
        out_ready = 1'b0;
        do_reset;
        chk("rst_mask", 32'(match_mask), 0);
        chk("rst_phase", 32'(best_phase), 0);
        chk("rst_score", 32'(best_score), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_locked", 32'(locked), 0);

        // 1: tap-2 window, exact latency
        feed(1'b1, 12);
        for (int i = 0; i < 6; i++) tick;
        chk("s1_valid_early", 32'(out_valid), 0);
        tick;
        chk("s1_valid", 32'(out_valid), 1);
        chk_res("s1", 2, 12, 6'b000100);
        for (int j = 0; j < 6; j++) chk($sformatf("s1_snap%0d", j), 32'(dut.snap[j]), 32'(snap_exp[j]));

        // 2: all-zero window, tie resolves to phase 0
        do_reset;
        feed(1'b0, 12);
        wait_valid("s2");
        chk_res("s2", 0, 6, 0);

        // 3: backpressure and overrun
        do_reset;
        feed(1'b1, 12);
        wait_valid("s3a");
        chk_res("s3a", 2, 12, 6'b000100);
        ov0 = ov_cnt;
        feed(1'b0, 12);
        for (int i = 0; i < 10; i++) tick;
        chk("s3_hold_valid", 32'(out_valid), 1);
        chk_res("s3_hold", 2, 12, 6'b000100);
        chk("s3_overrun_pulses", 32'(ov_cnt - ov0), 1);
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        chk("s3_consumed", 32'(out_valid), 0);

        // 4: lock acquisition and loss
        do_reset;
        out_ready = 1'b1;
        for (int w = 0; w < 2; w++) begin
            feed(1'b1, 12);
            for (int i = 0; i < 10; i++) tick;
            chk($sformatf("s4_unlocked_w%0d", w), 32'(locked), 0);
        end
        feed(1'b1, 12);
        for (int i = 0; i < 6; i++) tick;
        chk("s4_lock_early", 32'(locked), 0);
        tick;
        chk("s4_locked", 32'(locked), 1);
        chk("s4_phase", 32'(best_phase), 2);
        for (int i = 0; i < 3; i++) tick;
        feed(1'b0, 12);
        for (int i = 0; i < 10; i++) tick;
        chk("s4_lock_lost", 32'(locked), 0);
        out_ready = 1'b0;

        // 5a: en alternating, disabled cycles toggle sig
        do_reset;
        for (int i = 0; i < 24; i++) begin
            if (i % 2 == 0) feed(1'b1, 1);
            else begin
                en = 1'b0;
                sig = ~sig;
                tick;
            end
        end
        wait_valid("s5a");
        chk_res("s5a", 2, 12, 6'b000100);

        // 5b: reset mid-window discards partial work
        do_reset;
        feed(1'b1, 5);
        rst_in = 1'b1;
        tick;
        rst_in = 1'b0;
        code_m = 6'b000111;
        chk("s5b_rst_valid", 32'(out_valid), 0);
        feed(1'b1, 11);
        for (int i = 0; i < 10; i++) tick;
        chk("s5b_no_stale", 32'(out_valid), 0);
        feed(1'b1, 1);
        wait_valid("s5b");
        chk_res("s5b", 2, 12, 6'b000100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
